pg_input_arbiter: RTL and testbench

Round-robin packet arbiter that shares one `port_group` instance between `NUM_IN` upstream match/metadata channels. Each channel presents a 128-bit rule-match stream and one `metadata_t` descriptor per packet. The arbiter grants one channel at a time and forwards that channel's metadata and match beats to the port group unchanged. It holds the grant until the port group has taken both the match packet's eop beat and the metadata handshake. It sits between the per-lane string matchers and the `port_group` input.

---
 rtl/pg_input_arbiter.sv | 150 +++++++++++++++
 tb/tb_pg_input_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pg_input_arbiter
// Description : Round-robin packet arbiter sharing one port_group between
//               NUM_IN match/metadata channels; holds each grant for a packet.
// Revision    : 1.0 - initial release
// ============================================================================

package pg_input_arbiter_pkg;
  typedef struct packed {
    logic [31:0] flow_id;
    logic [15:0] pkt_len;
    logic [15:0] rule_id;
  } metadata_t;
endpackage

module pg_input_arbiter
  import pg_input_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int GW     = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_match_sop,
  input  logic [NUM_IN-1:0]        in_match_eop,
  input  logic [NUM_IN*128-1:0]    in_match_data,
  input  logic [NUM_IN*6-1:0]      in_match_empty,
  input  logic [NUM_IN-1:0]        in_match_valid,
  output logic [NUM_IN-1:0]        in_match_ready,
  input  logic [NUM_IN-1:0]        in_meta_valid,
  input  metadata_t [NUM_IN-1:0]   in_meta_data,
  output logic [NUM_IN-1:0]        in_meta_ready,
  output logic                     out_match_sop,
  output logic                     out_match_eop,
  output logic [127:0]             out_match_data,
  output logic [5:0]               out_match_empty,
  output logic                     out_match_valid,
  input  logic                     out_match_ready,
  output logic                     out_meta_valid,
  output metadata_t                out_meta_data,
  input  logic                     out_meta_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic [31:0]              pkt_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;
  logic          w_req_any;
  logic          w_busy;
  logic          r_eop_done;
  logic          r_meta_done;
  logic          w_eop_fire;
  logic          w_meta_fire;
  logic          w_eop_now;
  logic          w_meta_now;
  logic          w_complete;
  logic [31:0]   r_pkt_cnt;

  // Scan downward so the channel nearest last_grant+1 is written last and wins.
  always_comb begin
    w_req_any = |in_meta_valid;
    w_pick    = r_last_grant;
    w_idx     = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      w_idx = GW'((int'(r_last_grant) + k) % NUM_IN);
      if (in_meta_valid[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_busy          = (r_state == S_BUSY);
    out_match_sop   = in_match_sop[r_grant];
    out_match_eop   = in_match_eop[r_grant];
    out_match_data  = in_match_data[int'(r_grant)*128 +: 128];
    out_match_empty = in_match_empty[int'(r_grant)*6 +: 6];
    out_meta_data   = in_meta_data[r_grant];
    // Each side is closed off once its handshake has happened for this packet.
    out_match_valid = w_busy & ~r_eop_done & in_match_valid[r_grant];
    out_meta_valid  = w_busy & ~r_meta_done & in_meta_valid[r_grant];
    in_match_ready  = '0;
    in_meta_ready   = '0;
    in_match_ready[r_grant] = w_busy & ~r_eop_done & out_match_ready;
    in_meta_ready[r_grant]  = w_busy & ~r_meta_done & out_meta_ready;
  end

  assign w_eop_fire  = out_match_valid & out_match_ready & out_match_eop;
  assign w_meta_fire = out_meta_valid & out_meta_ready;
  assign w_eop_now   = r_eop_done | w_eop_fire;
  assign w_meta_now  = r_meta_done | w_meta_fire;
  assign w_complete  = w_busy & w_eop_now & w_meta_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_complete) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_IN - 1);
      r_eop_done   <= 1'b0;
      r_meta_done  <= 1'b0;
      r_pkt_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_req_any) begin
        r_grant     <= w_pick;
        r_eop_done  <= 1'b0;
        r_meta_done <= 1'b0;
      end
    end else if (w_complete) begin
      r_last_grant <= r_grant;
      r_pkt_cnt    <= r_pkt_cnt + 32'd1;
    end else begin
      r_eop_done  <= w_eop_now;
      r_meta_done <= w_meta_now;
    end
  end

  assign grant_id = r_grant;
  assign busy     = w_busy;
  assign pkt_cnt  = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pg_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pg_input_arbiter
// Description : Directed self-checking bench for pg_input_arbiter (NUM_IN=4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pg_input_arbiter;
  import pg_input_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      m_sop, m_eop, m_valid, m_ready;
  logic [511:0]    m_data;
  logic [23:0]     m_empty;
  logic [3:0]      meta_valid, meta_ready;
  metadata_t [3:0] meta_data;
  logic            o_sop, o_eop, o_valid;
  logic [127:0]    o_data;
  logic [5:0]      o_empty;
  logic            out_match_ready, out_meta_ready;
  logic            o_meta_valid;
  metadata_t       o_meta_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     pkt_cnt;

  int tests = 0;
  int fails = 0;

  pg_input_arbiter #(.NUM_IN(4), .GW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_match_sop(m_sop), .in_match_eop(m_eop), .in_match_data(m_data),
    .in_match_empty(m_empty), .in_match_valid(m_valid), .in_match_ready(m_ready),
    .in_meta_valid(meta_valid), .in_meta_data(meta_data), .in_meta_ready(meta_ready),
    .out_match_sop(o_sop), .out_match_eop(o_eop), .out_match_data(o_data),
    .out_match_empty(o_empty), .out_match_valid(o_valid), .out_match_ready(out_match_ready),
    .out_meta_valid(o_meta_valid), .out_meta_data(o_meta_data), .out_meta_ready(out_meta_ready),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input int ch, input int b);
    return {8'(ch), 8'(b), 112'h5A5A1234DEADBEEF0F0FC3C39696};
  endfunction

  function automatic metadata_t mkmeta(input int ch, input int n);
    metadata_t m;
    m.flow_id = 32'h1000 + 32'(ch);
    m.pkt_len = 16'(n);
    m.rule_id = 16'hBEEF;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int ch, input logic sop, input logic eop,
                            input logic vld, input logic [127:0] d, input logic [5:0] e);
    m_sop[ch]             = sop;
    m_eop[ch]             = eop;
    m_valid[ch]           = vld;
    m_data[ch*128 +: 128] = d;
    m_empty[ch*6 +: 6]    = e;
  endtask

  task automatic clear_inputs();
    m_sop = '0; m_eop = '0; m_valid = '0; m_data = '0; m_empty = '0;
    meta_valid = '0;
    for (int i = 0; i < 4; i++) meta_data[i] = mkmeta(i, 0);
    out_match_ready = 1'b0;
    out_meta_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    meta_valid[2] = 1'b1;
    meta_data[2]  = mkmeta(2, 7);
    drive_beat(2, 1'b1, 1'b1, 1'b1, mk(2, 0), 6'd3);
    out_match_ready = 1'b1;
    out_meta_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({m_ready, meta_ready, o_valid, o_meta_valid, busy} !== 11'd0) begin
        fails++;
        $display("FAIL reset_quiet cyc%0d: got %b required 0", i,
                 {m_ready, meta_ready, o_valid, o_meta_valid, busy});
      end
      tests++;
      if (pkt_cnt !== 32'd0 || grant_id !== 2'd0) begin
        fails++;
        $display("FAIL reset_regs cyc%0d: pkt_cnt=%0d grant=%0d required 0/0", i, pkt_cnt, grant_id);
      end
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      fails++;
      $display("FAIL reset_first_grant: busy=%b grant=%0d required 1/2", busy, grant_id);
    end
    tests++;
    if (o_valid !== 1'b1 || o_data !== mk(2, 0) || meta_ready !== 4'b0100 || o_meta_data !== mkmeta(2, 7)) begin
      fails++;
      $display("FAIL reset_forward: valid=%b data=%h meta_ready=%b required 1/%h/0100",
               o_valid, o_data, meta_ready, mk(2, 0));
    end
    tick();
    tests++;
    if (pkt_cnt !== 32'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_complete: pkt_cnt=%0d busy=%b required 1/0", pkt_cnt, busy);
    end
  endtask

  task automatic test_single_packet();
    int pulses = 0;
    do_reset();
    meta_valid[1] = 1'b1;
    meta_data[1]  = mkmeta(1, 3);
    drive_beat(1, 1'b1, 1'b0, 1'b1, mk(1, 0), 6'd0);
    out_match_ready = 1'b1;
    tick();
    pulses += int'(meta_ready[1]);
    tests++;
    if (grant_id !== 2'd1 || m_ready !== 4'b0010 || o_data !== mk(1, 0) || o_sop !== 1'b1) begin
      fails++;
      $display("FAIL single_beat0: grant=%0d ready=%b data=%h sop=%b required 1/0010/%h/1",
               grant_id, m_ready, o_data, o_sop, mk(1, 0));
    end
    tick();
    drive_beat(1, 1'b0, 1'b0, 1'b1, mk(1, 1), 6'd0);
    #1;
    pulses += int'(meta_ready[1]);
    tests++;
    if (o_data !== mk(1, 1) || o_sop !== 1'b0 || o_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_beat1: data=%h sop=%b valid=%b required %h/0/1", o_data, o_sop, o_valid, mk(1, 1));
    end
    tick();
    drive_beat(1, 1'b0, 1'b1, 1'b1, mk(1, 2), 6'd5);
    #1;
    pulses += int'(meta_ready[1]);
    tests++;
    if (o_data !== mk(1, 2) || o_eop !== 1'b1 || o_empty !== 6'd5) begin
      fails++;
      $display("FAIL single_beat2: data=%h eop=%b empty=%0d required %h/1/5", o_data, o_eop, o_empty, mk(1, 2));
    end
    tick();
    drive_beat(1, 1'b0, 1'b0, 1'b0, '0, 6'd0);
    #1;
    pulses += int'(meta_ready[1]);
    tests++;
    if (o_valid !== 1'b0 || m_ready !== 4'b0000 || busy !== 1'b1 ||
        o_meta_valid !== 1'b1 || o_meta_data !== mkmeta(1, 3)) begin
      fails++;
      $display("FAIL single_after_eop: valid=%b ready=%b busy=%b mvalid=%b required 0/0000/1/1",
               o_valid, m_ready, busy, o_meta_valid);
    end
    tick();
    out_meta_ready = 1'b1;
    #1;
    pulses += int'(meta_ready[1]);
    tick();
    meta_valid[1]  = 1'b0;
    out_meta_ready = 1'b0;
    #1;
    tests++;
    if (pkt_cnt !== 32'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: pkt_cnt=%0d busy=%b required 1/0", pkt_cnt, busy);
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL single_meta_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_round_robin();
    int   beat [4];
    logic fire [4];
    int   grants[$];
    logic prev_busy = 1'b0;
    int   exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    out_match_ready = 1'b1;
    out_meta_ready  = 1'b1;
    meta_valid      = 4'hF;
    for (int ch = 0; ch < 4; ch++) beat[ch] = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      for (int ch = 0; ch < 4; ch++)
        drive_beat(ch, beat[ch] == 0, beat[ch] == 1, 1'b1, mk(ch, beat[ch]), 6'd0);
      #1;
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
      if (pkt_cnt == 32'd8) break;
      for (int ch = 0; ch < 4; ch++) fire[ch] = m_ready[ch];
      tick();
      for (int ch = 0; ch < 4; ch++) if (fire[ch]) beat[ch] = 1 - beat[ch];
    end
    tests++;
    if (pkt_cnt !== 32'd8) begin
      fails++;
      $display("FAIL rr_pkt_cnt: got %0d required 8", pkt_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= grants.size()) begin
        fails++;
        $display("FAIL rr_grant%0d: got none required %0d", i, exp_g[i]);
      end else if (grants[i] != exp_g[i]) begin
        fails++;
        $display("FAIL rr_grant%0d: got %0d required %0d", i, grants[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int           idx = 0;
    int           other_bad = 0;
    logic         ch0fire;
    logic [127:0] recv[$];
    do_reset();
    meta_valid      = 4'b1011;
    out_meta_ready  = 1'b1;
    drive_beat(1, 1'b1, 1'b0, 1'b1, mk(1, 9), 6'd0);
    drive_beat(3, 1'b1, 1'b0, 1'b1, mk(3, 9), 6'd0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive_beat(0, idx == 0, idx == 3, idx < 4, mk(0, idx), 6'd0);
      out_match_ready = cyc[0];
      #1;
      if (pkt_cnt == 32'd1) break;
      if (m_ready[3:1] != 3'b000) other_bad++;
      if (o_valid && out_match_ready) recv.push_back(o_data);
      ch0fire = m_ready[0] & m_valid[0];
      tick();
      if (ch0fire) idx++;
    end
    tests++;
    if (pkt_cnt !== 32'd1) begin
      fails++;
      $display("FAIL bp_timeout: pkt_cnt=%0d required 1", pkt_cnt);
    end
    tests++;
    if (recv.size() != 4) begin
      fails++;
      $display("FAIL bp_beat_count: got %0d required 4", recv.size());
    end
    for (int i = 0; i < 4 && i < recv.size(); i++) begin
      tests++;
      if (recv[i] !== mk(0, i)) begin
        fails++;
        $display("FAIL bp_beat%0d: got %h required %h", i, recv[i], mk(0, i));
      end
    end
    tests++;
    if (other_bad != 0) begin
      fails++;
      $display("FAIL bp_other_ready: got %0d cycles with ready required 0", other_bad);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    meta_valid[2] = 1'b1;
    meta_data[2]  = mkmeta(2, 2);
    drive_beat(2, 1'b1, 1'b0, 1'b1, mk(2, 0), 6'd0);
    out_match_ready = 1'b1;
    tick();
    tests++;
    if (grant_id !== 2'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL same_grant: grant=%0d busy=%b required 2/1", grant_id, busy);
    end
    tick();
    drive_beat(2, 1'b0, 1'b1, 1'b1, mk(2, 1), 6'd0);
    out_meta_ready = 1'b1;
    #1;
    tests++;
    if (m_ready !== 4'b0100 || meta_ready !== 4'b0100) begin
      fails++;
      $display("FAIL same_readies: match=%b meta=%b required 0100/0100", m_ready, meta_ready);
    end
    tick();
    drive_beat(2, 1'b1, 1'b1, 1'b1, mk(2, 5), 6'd0);
    out_meta_ready = 1'b0;
    #1;
    tests++;
    if (pkt_cnt !== 32'd1 || busy !== 1'b0 || m_ready !== 4'b0000 || meta_ready !== 4'b0000) begin
      fails++;
      $display("FAIL same_complete: pkt_cnt=%0d busy=%b match=%b meta=%b required 1/0/0000/0000",
               pkt_cnt, busy, m_ready, meta_ready);
    end
    tick();
    tests++;
    if (busy !== 1'b1 || m_ready !== 4'b0100 || o_data !== mk(2, 5) || o_sop !== 1'b1) begin
      fails++;
      $display("FAIL same_regrant: busy=%b ready=%b data=%h required 1/0100/%h", busy, m_ready, o_data, mk(2, 5));
    end
    tick();
    drive_beat(2, 1'b1, 1'b0, 1'b1, mk(2, 6), 6'd0);
    #1;
    tests++;
    if (m_ready !== 4'b0000 || o_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL early_sop_gate: ready=%b valid=%b busy=%b required 0000/0/1", m_ready, o_valid, busy);
    end
    out_meta_ready = 1'b1;
    tick();
    tests++;
    if (pkt_cnt !== 32'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL early_complete: pkt_cnt=%0d busy=%b required 2/0", pkt_cnt, busy);
    end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    meta_valid[3] = 1'b1;
    meta_data[3]  = mkmeta(3, 4);
    drive_beat(3, 1'b1, 1'b0, 1'b1, mk(3, 0), 6'd0);
    out_match_ready = 1'b1;
    tick();
    tick();
    drive_beat(3, 1'b0, 1'b0, 1'b1, mk(3, 1), 6'd0);
    tick();
    drive_beat(3, 1'b0, 1'b0, 1'b1, mk(3, 2), 6'd0);
    rst_n = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || o_valid !== 1'b0 || m_ready !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset_idle: busy=%b grant=%0d valid=%b ready=%b required 0/0/0/0000",
               busy, grant_id, o_valid, m_ready);
    end
    rst_n = 1'b1;
    meta_data[3] = mkmeta(3, 1);
    drive_beat(3, 1'b1, 1'b1, 1'b1, mk(3, 8), 6'd2);
    out_meta_ready = 1'b1;
    tick();
    tests++;
    if (grant_id !== 2'd3 || o_data !== mk(3, 8) || o_sop !== 1'b1 || o_eop !== 1'b1 ||
        o_empty !== 6'd2 || o_meta_data !== mkmeta(3, 1)) begin
      fails++;
      $display("FAIL mid_reset_next: grant=%0d data=%h sop=%b eop=%b required 3/%h/1/1",
               grant_id, o_data, o_sop, o_eop, mk(3, 8));
    end
    tick();
    tests++;
    if (pkt_cnt !== 32'd1) begin
      fails++;
      $display("FAIL mid_reset_count: got %0d required 1", pkt_cnt);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_same_cycle();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
